// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO map for the core's store-side responder: window base, register
// offsets and the queued entry format.
package riscv_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_1000;

  // Word offsets inside the 256-byte window (byte addr = base + 4*ofs)
  localparam logic [5:0] CONSOLE_OFS  = 6'h00;
  localparam logic [5:0] SIG_OFS      = 6'h01;
  localparam logic [5:0] HALT_OFS_DEF = 6'h3F;

  typedef struct packed {
    logic [5:0]  ofs;
    logic [31:0] data;
  } mmio_entry_t;

  function automatic logic [5:0] word_ofs(input logic [31:0] byte_addr);
    return byte_addr[7:2];
  endfunction

endpackage

// File: rtl/mmio_store_sink_if.sv
// Store bus from the core plus the valid/ready drain channel to the consumer.
interface mmio_store_sink_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        we;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_ofs;
  logic [31:0] out_data;

  modport master (
    output addr, data, we, out_ready,
    input  out_valid, out_ofs, out_data
  );

  modport slave (
    input  addr, data, we, out_ready,
    output out_valid, out_ofs, out_data
  );
endinterface

// File: rtl/mmio_store_sink_sync_fifo.sv
// Registered-storage FIFO; occupancy comes from a dedicated counter so pointers
// can wrap freely. A push into a full queue succeeds only alongside a pop.
module sync_fifo #(
  parameter  int WIDTH = 38,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [LW-1:0]               count;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_store_sink.sv
// MMIO store responder: decodes window stores, queues them for a downstream
// consumer and latches a sticky halt flag/code from the HALT word.
module mmio_store_sink
  import riscv_mmio_pkg::*;
#(
  parameter  logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
  parameter  int          FIFO_DEPTH = 4,
  parameter  logic [5:0]  HALT_OFS   = HALT_OFS_DEF,
  localparam int          LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_store_sink_if.slave     bus,
  output logic [LW-1:0]        fifo_level,
  output logic [15:0]          drop_count,
  output logic                 misalign_err,
  output logic                 halt,
  output logic [31:0]          halt_code
);

  logic        in_win, aligned, live, is_halt_wr, push_req, pop, full, empty;
  logic [5:0]  ofs;
  mmio_entry_t in_ent, head;

  assign ofs     = word_ofs(bus.addr);
  assign in_win  = bus.we & (bus.addr[31:8] == MMIO_BASE[31:8]);
  assign aligned = (bus.addr[1:0] == 2'b00);
  // After halt every store is ignored, misaligned ones included
  assign live       = in_win & ~halt;
  assign is_halt_wr = live & aligned & (ofs == HALT_OFS);
  assign push_req   = live & aligned & (ofs != HALT_OFS);
  assign pop        = bus.out_valid & bus.out_ready;
  assign in_ent     = '{ofs: ofs, data: bus.data};

  sync_fifo #(
    .WIDTH ($bits(mmio_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (in_ent),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_ofs   = head.ofs;
  assign bus.out_data  = head.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count   <= '0;
      misalign_err <= 1'b0;
      halt         <= 1'b0;
      halt_code    <= '0;
    end else begin
      if (live & ~aligned) misalign_err <= 1'b1;
      if (is_halt_wr) begin
        halt      <= 1'b1;
        halt_code <= bus.data;
      end
      // A full queue only loses the store when the head is not leaving too
      if (push_req & full & ~pop & (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mmio_store_sink.sv
// Bench for mmio_store_sink: hand-computed vector table, directed halt/reset
// sequences, then random traffic against a queue-based reference model.
module tb_mmio_store_sink;
  import riscv_mmio_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_count;
  logic          misalign_err, halt;
  logic [31:0]   halt_code;

  mmio_store_sink_if bus();

  mmio_store_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count),
    .misalign_err (misalign_err),
    .halt         (halt),
    .halt_code    (halt_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue plus sticky flags
  mmio_entry_t mq[$];
  bit          m_halt, m_mis;
  logic [31:0] m_code;
  int          m_drop;

  task automatic model_reset();
    mq.delete();
    m_halt = 0; m_mis = 0; m_code = '0; m_drop = 0;
  endtask

  task automatic model_step(input logic [31:0] a, d, input logic w, r);
    bit do_pop  = r && (mq.size() > 0);
    bit do_push = 0;
    if (w && a[31:8] == 24'h000010 && !m_halt) begin
      if (a[1:0] != 2'b00)       m_mis = 1;
      else if (a[7:2] == 6'h3F) begin m_halt = 1; m_code = d; end
      else                       do_push = 1;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back('{ofs: a[7:2], data: d});
      else if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic model_check();
    chk("m_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_ofs",  32'(bus.out_ofs), 32'(mq[0].ofs));
      chk("m_data", bus.out_data, mq[0].data);
    end
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_drop",  32'(drop_count), 32'(m_drop));
    chk("m_mis",   32'(misalign_err), 32'(m_mis));
    chk("m_halt",  32'(halt), 32'(m_halt));
    if (m_halt) chk("m_code", halt_code, m_code);
  endtask

  task automatic step(input logic [31:0] a, d, input logic w, r);
    @(negedge clk);
    bus.addr = a; bus.data = d; bus.we = w; bus.out_ready = r;
    @(posedge clk);
    model_step(a, d, w, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.addr = '0; bus.data = '0; bus.we = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ofs",   32'(bus.out_ofs), 32'd0);
    chk("rst_data",  bus.out_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    chk("rst_mis",   32'(misalign_err), 32'd0);
    chk("rst_halt",  32'(halt), 32'd0);
    chk("rst_code",  halt_code, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr, data;
    logic        we, rdy;
    logic        ev;
    logic [5:0]  eofs;
    logic [31:0] edata;
    int          elvl, edrop;
    logic        emis;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [31:0] a, d, logic w, r, logic ev, logic [5:0] eo,
                              logic [31:0] ed, int el, edr, logic em);
    vec_t v;
    v.addr = a; v.data = d; v.we = w; v.rdy = r; v.ev = ev; v.eofs = eo;
    v.edata = ed; v.elvl = el; v.edrop = edr; v.emis = em;
    return v;
  endfunction

  initial begin
    bus.addr = '0; bus.data = '0; bus.we = 1'b0; bus.out_ready = 1'b0;

    // Expected state is what the outputs show just after the edge that applied the row
    tv.push_back(mk(32'h1000, 32'h5,  1, 1, 1, 6'd0, 32'h5,  1, 0, 0));
    tv.push_back(mk(32'h1004, 32'hA,  1, 1, 1, 6'd1, 32'hA,  1, 0, 0));
    tv.push_back(mk(32'h0,    32'h0,  0, 1, 0, 6'd0, 32'h0,  0, 0, 0));
    tv.push_back(mk(32'h1002, 32'h3,  1, 1, 0, 6'd0, 32'h0,  0, 0, 1));
    tv.push_back(mk(32'h0,    32'h4,  1, 1, 0, 6'd0, 32'h0,  0, 0, 1));
    for (int i = 0; i < 6; i++)
      tv.push_back(mk(32'h1000 + 32'(4*i), 32'h10 + 32'(i), 1, 0, 1, 6'd0, 32'h10,
                      (i < 4) ? i + 1 : 4, (i < 4) ? 0 : i - 3, 1));
    tv.push_back(mk(32'h1018, 32'h66, 1, 1, 1, 6'd1, 32'h11, 4, 2, 1));
    tv.push_back(mk(32'h0,    32'h0,  0, 1, 1, 6'd2, 32'h12, 3, 2, 1));
    tv.push_back(mk(32'h0,    32'h0,  0, 1, 1, 6'd3, 32'h13, 2, 2, 1));
    tv.push_back(mk(32'h0,    32'h0,  0, 1, 1, 6'd6, 32'h66, 1, 2, 1));
    tv.push_back(mk(32'h0,    32'h0,  0, 1, 0, 6'd0, 32'h0,  0, 2, 1));

    do_reset();
    foreach (tv[i]) begin
      step(tv[i].addr, tv[i].data, tv[i].we, tv[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_ofs", i),  32'(bus.out_ofs), 32'(tv[i].eofs));
        chk($sformatf("v%0d_data", i), bus.out_data, tv[i].edata);
      end
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tv[i].elvl));
      chk($sformatf("v%0d_drop", i),  32'(drop_count), 32'(tv[i].edrop));
      chk($sformatf("v%0d_mis", i),   32'(misalign_err), 32'(tv[i].emis));
      chk($sformatf("v%0d_halt", i),  32'(halt), 32'd0);
    end

    // Halt: later stores (repeat HALT included) are ignored, earlier entries drain
    step(32'h1008, 32'h21, 1, 0);
    step(32'h100C, 32'h22, 1, 0);
    step(32'h10FC, 32'h9,  1, 0);
    chk("halt_set",  32'(halt), 32'd1);
    chk("halt_code", halt_code, 32'h9);
    chk("halt_lvl",  32'(fifo_level), 32'd2);
    step(32'h10FC, 32'h7, 1, 0);
    step(32'h1000, 32'h1, 1, 0);
    chk("halt_code2", halt_code, 32'h9);
    chk("halt_lvl2",  32'(fifo_level), 32'd2);
    chk("halt_head_ofs",  32'(bus.out_ofs), 32'd2);
    chk("halt_head_data", bus.out_data, 32'h21);
    step(32'h0, 32'h0, 0, 1);
    chk("halt_drain_ofs",  32'(bus.out_ofs), 32'd3);
    chk("halt_drain_data", bus.out_data, 32'h22);
    step(32'h0, 32'h0, 0, 1);
    chk("halt_empty", 32'(bus.out_valid), 32'd0);
    chk("halt_drop",  32'(drop_count), 32'd2);

    // Asynchronous reset in the middle of a cycle with state built up
    do_reset();
    step(32'h1001, 32'h0, 1, 0);
    step(32'h1000, 32'h1, 1, 0);
    step(32'h1004, 32'h2, 1, 0);
    step(32'h1008, 32'h3, 1, 0);
    step(32'h10FC, 32'hBEEF, 1, 0);
    chk("pre_arst_lvl",  32'(fifo_level), 32'd3);
    chk("pre_arst_halt", 32'(halt), 32'd1);
    chk("pre_arst_mis",  32'(misalign_err), 32'd1);
    bus.we = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_halt",  32'(halt), 32'd0);
    chk("arst_mis",   32'(misalign_err), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;

    // Random traffic against the reference model
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        logic [31:0] a;
        int          sel = $urandom_range(0, 99);
        if (sel < 8) begin
          a = $urandom;
          if (a[31:8] == 24'h000010) a[20] = 1'b1;
        end else if (sel < 14) begin
          a = 32'h1000 | 32'($urandom_range(0, 255));
          if (a[1:0] == 2'b00) a[0] = 1'b1;
        end else if (sel < 15) begin
          a = 32'h10FC;
        end else begin
          a = 32'h1000 | (32'($urandom_range(0, 62)) << 2);
        end
        step(a, $urandom, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
        model_check();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
